// File: rtl/dmem_dump_arbiter.sv
// dmem_dump_arbiter: shares the MEM-stage data-memory port between the pipeline and a debug memory dump.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_pipe_*              pipeline load/store request; o_pipe_rdata returns read data
//   i_dbg_halt            pipeline halted (level); a dump may only start and continue while high
//   i_dbg_dump_start      one-cycle dump request
//   o_dbg_valid/data      dump word stream, accepted with i_dbg_ready
//   o_dump_busy           dump in progress, pipeline cut off from memory
//   o_dump_done           one-cycle pulse after the last word is accepted
//   o_mem_*, i_mem_rdata  data memory port (read data one cycle after read issued)
//   o_dump_checksum       XOR of accepted dump words (only with DMEM_DUMP_CHECKSUM_EN)
module dmem_dump_arbiter #(
    parameter int NB_BITS  = 32,
    parameter int NB_DEPTH = 10
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_BITS-1:0] i_pipe_addr,
    input  logic [NB_BITS-1:0] i_pipe_wdata,
    input  logic [1:0]         i_pipe_write_ctl,
    input  logic [1:0]         i_pipe_read_ctl,
    output logic [NB_BITS-1:0] o_pipe_rdata,
    input  logic               i_dbg_halt,
    input  logic               i_dbg_dump_start,
    input  logic               i_dbg_ready,
    output logic               o_dbg_valid,
    output logic [NB_BITS-1:0] o_dbg_data,
    output logic               o_dump_busy,
    output logic               o_dump_done,
    output logic [NB_BITS-1:0] o_mem_addr,
    output logic [NB_BITS-1:0] o_mem_wdata,
    output logic [1:0]         o_mem_write_ctl,
    output logic [1:0]         o_mem_read_ctl,
    input  logic [NB_BITS-1:0] i_mem_rdata
`ifdef DMEM_DUMP_CHECKSUM_EN
    ,
    output logic [NB_BITS-1:0] o_dump_checksum
`endif
);
    typedef enum logic [2:0] {PIPE, RD, WAIT, OUT, DONE} state_t;
    state_t state, state_nxt;
    logic [NB_DEPTH-1:0] cnt;
    logic [NB_BITS-1:0] data_q;
    logic last, hs, abort, pipe;
    assign pipe  = state == PIPE;
    assign last  = &cnt;
    // abort has priority over a handshake in the same cycle
    assign abort = !i_dbg_halt && (state inside {RD, WAIT, OUT});
    assign hs    = state == OUT && i_dbg_ready && i_dbg_halt;
    always_comb begin
        state_nxt = state;
        case (state)
            PIPE:    state_nxt = i_dbg_dump_start && i_dbg_halt ? RD : PIPE;
            RD:      state_nxt = abort ? PIPE : WAIT;
            WAIT:    state_nxt = abort ? PIPE : OUT;
            OUT:     state_nxt = abort ? PIPE : hs ? (last ? DONE : RD) : OUT;
            DONE:    state_nxt = PIPE;
            default: state_nxt = PIPE;
        endcase
    end
    assign o_mem_addr      = pipe ? i_pipe_addr : state == RD ? NB_BITS'({cnt, 2'b00}) : '0;
    assign o_mem_wdata     = pipe ? i_pipe_wdata : '0;
    assign o_mem_write_ctl = pipe ? i_pipe_write_ctl : 2'b00;
    assign o_mem_read_ctl  = pipe ? i_pipe_read_ctl : state == RD ? 2'b11 : 2'b00;
    assign o_pipe_rdata    = pipe ? i_mem_rdata : '0;
    assign o_dump_busy     = !pipe;
    assign o_dbg_valid     = state == OUT;
    assign o_dbg_data      = data_q;
    assign o_dump_done     = state == DONE;
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state  <= PIPE;
            cnt    <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            if (abort || state == DONE) cnt <= '0;
            else if (hs && !last) cnt <= cnt + NB_DEPTH'(1);
            if (state == WAIT) data_q <= i_mem_rdata;
        end
    end
`ifdef DMEM_DUMP_CHECKSUM_EN
    logic [NB_BITS-1:0] ck_q;
    assign o_dump_checksum = ck_q;
    always_ff @(posedge i_clk) begin
        if (!i_rst) ck_q <= '0;
        else if (pipe && state_nxt == RD) ck_q <= '0;
        else if (hs) ck_q <= ck_q ^ data_q;
    end
`endif
endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// tb_dmem_dump_arbiter: random-data dump, stall, abort and isolation checks against a word-level memory model.
module tb_dmem_dump_arbiter;
    localparam int WORDS = 4;
    logic        clk = 0, rst = 0;
    logic [31:0] pipe_addr = 0, pipe_wdata = 0, pipe_rdata;
    logic [1:0]  pipe_wc = 0, pipe_rc = 0;
    logic        halt = 0, start = 0, ready = 1;
    logic        dbg_valid, busy, done;
    logic [31:0] dbg_data, mem_addr, mem_wdata, mem_rdata = 0;
    logic [1:0]  mem_wc, mem_rc;
    logic [31:0] ck_out;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int          n_cmp = 0, n_err = 0, cyc = 0;

    dmem_dump_arbiter #(.NB_BITS(32), .NB_DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_pipe_addr(pipe_addr), .i_pipe_wdata(pipe_wdata),
        .i_pipe_write_ctl(pipe_wc), .i_pipe_read_ctl(pipe_rc), .o_pipe_rdata(pipe_rdata),
        .i_dbg_halt(halt), .i_dbg_dump_start(start), .i_dbg_ready(ready),
        .o_dbg_valid(dbg_valid), .o_dbg_data(dbg_data),
        .o_dump_busy(busy), .o_dump_done(done),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_write_ctl(mem_wc), .o_mem_read_ctl(mem_rc), .i_mem_rdata(mem_rdata)
`ifdef DMEM_DUMP_CHECKSUM_EN
        , .o_dump_checksum(ck_out)
`endif
    );
`ifndef DMEM_DUMP_CHECKSUM_EN
    assign ck_out = '0;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) begin
        if (mem_wc != 2'b00) mem[mem_addr[5:2]] <= mem_wdata;
        if (mem_rc != 2'b00) mem_rdata <= mem[mem_addr[5:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe_write(input logic [31:0] a, input logic [31:0] d);
        pipe_addr = a; pipe_wdata = d; pipe_wc = 2'b11; pipe_rc = 2'b00;
        tick();
        pipe_wc = 2'b00;
        ref_mem[a[5:2]] = d;
    endtask

    task automatic dump(input int stall_w, input int stall_n, input int abort_w);
        logic [31:0] ck;
        int rd_prev, n;
        ck = '0;
        rd_prev = -1;
        ready = 1; halt = 1; start = 1;
        tick();
        start = 0;
        pipe_addr = 32'(4 * $urandom_range(0, WORDS - 1));
        pipe_wdata = $urandom; pipe_wc = 2'b11; pipe_rc = 2'b11;
        for (int w = 0; w < WORDS; w++) begin
            n = 0;
            while (mem_rc != 2'b11 && n < 8) begin tick(); n++; end
            check("rd_issue", 32'(n < 8), 1);
            check("rd_addr", mem_addr, 32'(4 * w));
            check("wr_block", 32'(mem_wc), 0);
            check("pipe_rdata_zero", pipe_rdata, 0);
            check("busy", 32'(busy), 1);
            if (rd_prev >= 0) check("rate", 32'(cyc - rd_prev), 3);
            rd_prev = (w == stall_w) ? -1 : cyc;
            n = 0;
            while (!dbg_valid && n < 8) begin tick(); n++; end
            check("valid_wait", 32'(n < 8), 1);
            check("dbg_data", dbg_data, ref_mem[w]);
            if (w == stall_w) begin
                ready = 0;
                for (int k = 0; k < stall_n; k++) begin
                    tick();
                    check("stall_valid", 32'(dbg_valid), 1);
                    check("stall_data", dbg_data, ref_mem[w]);
                    check("stall_no_rd", 32'(mem_rc), 0);
                end
                ready = 1;
            end
            if (w == abort_w) begin
                halt = 0; pipe_wc = 2'b00; pipe_rc = 2'b00;
                tick();
                check("abort_busy", 32'(busy), 0);
                check("abort_valid", 32'(dbg_valid), 0);
                check("abort_done", 32'(done), 0);
                tick();
                check("abort_done2", 32'(done), 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
                check("abort_cksum", ck_out, ck);
`endif
                return;
            end
            tick();
            ck ^= ref_mem[w];
        end
        check("done_pulse", 32'(done), 1);
        check("done_busy", 32'(busy), 1);
        check("done_no_wr", 32'(mem_wc), 0);
        pipe_wc = 2'b00; pipe_rc = 2'b00;
        tick();
        check("done_clear", 32'(done), 0);
        check("idle_busy", 32'(busy), 0);
`ifdef DMEM_DUMP_CHECKSUM_EN
        check("cksum", ck_out, ck);
`endif
        halt = 0;
        for (int i = 0; i < WORDS; i++) check("mem_keep", mem[i], ref_mem[i]);
    endtask

    initial begin
        tick(); tick();
        check("rst_valid", 32'(dbg_valid), 0);
        check("rst_data", dbg_data, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cksum", ck_out, 0);
        rst = 1;
        tick();
        // transparent pipeline path, including the store example
        for (int i = 0; i < 10; i++) begin
            pipe_addr  = (i == 0) ? 32'h8 : 32'(4 * $urandom_range(0, 15));
            pipe_wdata = (i == 0) ? 32'hDEADBEEF : $urandom;
            pipe_wc    = (i == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            pipe_rc    = 2'($urandom_range(0, 3));
            #1;
            check("pass_addr", mem_addr, pipe_addr);
            check("pass_wdata", mem_wdata, pipe_wdata);
            check("pass_wc", 32'(mem_wc), 32'(pipe_wc));
            check("pass_rc", 32'(mem_rc), 32'(pipe_rc));
            check("pass_rdata", pipe_rdata, mem_rdata);
            check("pass_busy", 32'(busy), 0);
            if (pipe_wc != 2'b00) ref_mem[pipe_addr[5:2]] = pipe_wdata;
            tick();
        end
        pipe_wc = 0; pipe_rc = 0;
        for (int i = 0; i < WORDS; i++) pipe_write(32'(4 * i), 32'(17 * (i + 1)));
        dump(-1, 0, -1);
        // start without halt is ignored and forgotten
        start = 1;
        tick();
        start = 0;
        check("nohalt_busy", 32'(busy), 0);
        halt = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("nohalt_later_busy", 32'(busy), 0);
            check("nohalt_later_rd", 32'(mem_rc), 0);
        end
        halt = 0;
        tick();
        dump(1, 5, -1);
        dump(-1, 0, 0);
        dump(-1, 0, -1);
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < WORDS; i++) pipe_write(32'(4 * i), $urandom);
            dump($urandom_range(0, 4) - 1, $urandom_range(1, 6), $urandom_range(0, 5) - 1);
            tick();
        end
        // reset while a word is on offer
        halt = 1; start = 1;
        tick();
        start = 0; ready = 0;
        for (int n = 0; n < 8 && !dbg_valid; n++) tick();
        check("pre_rst_valid", 32'(dbg_valid), 1);
        rst = 0;
        tick();
        rst = 1;
        check("rst2_valid", 32'(dbg_valid), 0);
        check("rst2_data", dbg_data, 0);
        check("rst2_busy", 32'(busy), 0);
        check("rst2_done", 32'(done), 0);
        check("rst2_cksum", ck_out, 0);
        check("rst2_addr", mem_addr, pipe_addr);
        halt = 0; ready = 1;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_dump_arbiter.md
Name: dmem_dump_arbiter

Overview:
- Owns the single data-memory port in the MEM stage. Shares it between the pipeline load/store path and the debug unit.
- In normal operation the pipeline drives the port transparently.
- While the pipeline is halted, the debug unit can request a full memory dump. The block sequences word reads over all locations and streams them out with a valid/ready handshake.

Parameters:
- NB_BITS, 32, data/address width
- NB_DEPTH, 10, log2 of memory depth in words; dump covers words 0 .. 2^NB_DEPTH-1

Ports:
- i_clk  input  1  clock, all logic on rising edge
- i_rst  input  1  reset; synchronous, active-low (0 = reset)
- i_pipe_addr  input  NB_BITS  pipeline byte address
- i_pipe_wdata  input  NB_BITS  pipeline store data
- i_pipe_write_ctl  input  2  pipeline write enable/size
- i_pipe_read_ctl  input  2  pipeline read enable/size
- o_pipe_rdata  output  NB_BITS  memory read data returned to pipeline
- i_dbg_halt  input  1  pipeline halted by debug unit; level
- i_dbg_dump_start  input  1  one-cycle dump request
- i_dbg_ready  input  1  debug consumer accepts word
- o_dbg_valid  output  1  o_dbg_data holds a dump word
- o_dbg_data  output  NB_BITS  dumped word
- o_dump_busy  output  1  dump in progress; pipeline port blocked
- o_dump_done  output  1  one-cycle pulse after last word accepted
- o_mem_addr  output  NB_BITS  to data memory
- o_mem_wdata  output  NB_BITS  to data memory
- o_mem_write_ctl  output  2  to data memory
- o_mem_read_ctl  output  2  to data memory
- i_mem_rdata  input  NB_BITS  from data memory; valid 1 cycle after read issued

Behaviour:
- Reset (i_rst=0 at posedge): state=PIPE, word counter=0, data register=0.
  - After reset: o_dbg_valid=0, o_dbg_data=0, o_dump_busy=0, o_dump_done=0.
  - Memory outputs follow pipeline inputs, since the state is PIPE.
- States: PIPE, RD, WAIT, OUT, DONE.
- PIPE:
  - o_mem_* = i_pipe_* combinationally; o_pipe_rdata = i_mem_rdata; o_dump_busy=0.
  - Transition to RD only when i_dbg_dump_start=1 and i_dbg_halt=1.
  - A start pulse with i_dbg_halt=0 is ignored and not remembered.
- RD:
  - o_mem_addr = {counter, 2'b00}, zero-extended to NB_BITS.
  - o_mem_read_ctl=2'b11 (word), o_mem_write_ctl=2'b00, o_mem_wdata=0.
  - Next state: WAIT.
- WAIT:
  - Memory controls idle (read/write ctl = 0).
  - Capture i_mem_rdata into the data register; next state: OUT.
- OUT:
  - o_dbg_valid=1; o_dbg_data holds the captured word stable until accepted.
  - Handshake: i_dbg_ready=1 in OUT.
  - On handshake at counter = 2^NB_DEPTH-1: go to DONE.
  - On handshake otherwise: counter+1, go to RD.
  - Without i_dbg_ready: stay in OUT indefinitely.
- DONE: o_dump_done=1 for exactly one cycle; counter cleared; next state: PIPE.
- Pipeline isolation:
  - o_dump_busy=1 in RD, WAIT, OUT and DONE.
  - In these states pipeline ctl inputs never reach memory; no pipeline write is ever issued.
  - o_pipe_rdata is driven 0 in these states.
- Abort: i_dbg_halt falling to 0 in RD, WAIT or OUT:
  - Next state is PIPE; counter cleared; o_dbg_valid drops.
  - No o_dump_done pulse.
- i_dbg_dump_start while a dump is busy: ignored.
- Counter is NB_DEPTH bits wide; the terminal-count compare prevents wrap-around.
- Throughput: 3 cycles per word when i_dbg_ready is held at 1.

Optional Feature:
- Macro: DMEM_DUMP_CHECKSUM_EN.
- Defined:
  - Adds output o_dump_checksum [NB_BITS-1:0].
  - A running XOR register is cleared on entering RD from PIPE.
  - Every accepted word (OUT handshake) is XORed into the register.
  - The register holds its value after DONE until the next dump starts; reset value 0.
  - An abort leaves the partial value.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan (NB_DEPTH=2, i.e. 4 words):
- Pipeline store addr 0x8, data 0xDEADBEEF, write_ctl 2'b11, i_dbg_halt=0 -> o_mem_* mirrors the inputs in the same cycle; o_dump_busy=0.
- Memory preloaded with 0x11, 0x22, 0x33, 0x44; halt=1, start pulse, ready=1 -> o_mem_addr 0x0, 0x4, 0x8, 0xC.
  - o_dbg_data 0x11, 0x22, 0x33, 0x44, one word every 3 cycles.
  - o_dump_done pulses 1 cycle after the 4th handshake.
  - With DMEM_DUMP_CHECKSUM_EN, o_dump_checksum = 0x44.
- Same dump with i_dbg_ready held 0 for 5 cycles on word 2 -> o_dbg_valid=1 and o_dbg_data=0x22 stable for those cycles; no new memory read is issued.
- Start pulse with halt=0 -> state stays PIPE; o_dump_busy=0; a later halt=1 without a new pulse starts no dump.
- Halt drops while OUT on word 1 -> PIPE the next cycle; no done pulse; a fresh dump restarts at address 0x0.
- During a dump, drive pipeline write_ctl=2'b11 -> o_mem_write_ctl=0 and memory is unchanged.
  - Assert i_rst=0 while in OUT -> all outputs return to their reset values the next cycle.
